credit_manager: RTL and testbench

Customer-side transaction controller for the vending machine. It accumulates inserted coins into an 8-bit credit balance and turns a product button press into the buy/product request handshake toward the purchase manager. It then consumes the purchase manager's dispense or error pulse, deducts the price on success, and pays the remaining credit back as change, one coin per cycle.

---
 rtl/vend_pkg.sv | 54 +++++
 rtl/change_dispenser.sv | 26 ++
 rtl/credit_manager.sv | 163 ++++++++++++++++
 tb/tb_credit_manager.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine types: product/coin codes, prices, coin values and the
// credit_manager state encoding. The purchase manager prices from the same constants.
package vend_pkg;

    typedef enum logic [1:0] {
        PROD_APPLE  = 2'b00,
        PROD_BANANA = 2'b01,
        PROD_CARROT = 2'b10,
        PROD_DATE   = 2'b11
    } product_e;

    typedef enum logic [1:0] {
        COIN_5   = 2'b00,
        COIN_10  = 2'b01,
        COIN_25  = 2'b10,
        COIN_100 = 2'b11
    } coin_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_WAIT   = 2'b10,
        ST_CHANGE = 2'b11
    } state_e;

    localparam logic [7:0] PRICE_APPLE  = 8'd75;
    localparam logic [7:0] PRICE_BANANA = 8'd20;
    localparam logic [7:0] PRICE_CARROT = 8'd30;
    localparam logic [7:0] PRICE_DATE   = 8'd40;

    localparam logic [7:0] VAL_5   = 8'd5;
    localparam logic [7:0] VAL_10  = 8'd10;
    localparam logic [7:0] VAL_25  = 8'd25;
    localparam logic [7:0] VAL_100 = 8'd100;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:   coin_value = VAL_5;
            COIN_10:  coin_value = VAL_10;
            COIN_25:  coin_value = VAL_25;
            default:  coin_value = VAL_100;
        endcase
    endfunction

    function automatic logic [7:0] price_of(input logic [1:0] prod);
        case (prod)
            PROD_APPLE:  price_of = PRICE_APPLE;
            PROD_BANANA: price_of = PRICE_BANANA;
            PROD_CARROT: price_of = PRICE_CARROT;
            default:     price_of = PRICE_DATE;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// Greedy change selector: picks the largest of 25/10/5 that fits in the balance.
// A balance below 5 yields value 0, which the caller treats as "nothing to pay".
module change_dispenser
    import vend_pkg::*;
(
    input  logic [7:0] balance_i,
    output logic [1:0] coin_code_o,
    output logic [7:0] coin_value_o
);

    always_comb begin
        coin_code_o  = COIN_5;
        coin_value_o = 8'd0;
        if (balance_i >= VAL_25) begin
            coin_code_o  = COIN_25;
            coin_value_o = VAL_25;
        end else if (balance_i >= VAL_10) begin
            coin_code_o  = COIN_10;
            coin_value_o = VAL_10;
        end else if (balance_i >= VAL_5) begin
            coin_code_o  = COIN_5;
            coin_value_o = VAL_5;
        end
    end

endmodule

// File: rtl/credit_manager.sv
// Customer-side vending controller: accumulates coins, issues buy requests, settles
// the purchase response and pays remaining credit back one coin per cycle.
module credit_manager
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT   = 250,
    parameter int RESP_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       select_valid,
    input  logic [1:0] select_product,
    input  logic       cancel,
    input  logic       apple,
    input  logic       banana,
    input  logic       carrot,
    input  logic       date,
    input  logic       error,
    output logic       buy,
    output logic [1:0] product,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       vend_ok,
    output logic       vend_fail,
    output logic       change_valid,
    output logic [1:0] change_coin,
    output logic       busy,
    output state_e     state_dbg
);

    localparam int TW = $clog2(RESP_TIMEOUT + 1);

    state_e         state_q, state_d;
    logic [7:0]     credit_q, credit_d;
    logic [1:0]     product_q, product_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           buy_q, buy_d;
    logic           coin_reject_q, coin_reject_d;
    logic           vend_ok_q, vend_ok_d;
    logic           vend_fail_q, vend_fail_d;
    logic           change_valid_q, change_valid_d;
    logic [1:0]     change_coin_q, change_coin_d;

    logic [8:0]     coin_sum;
    logic           coin_fits;
    logic [3:0]     dispense;
    logic           any_resp;
    logic           one_hot;
    logic [7:0]     price;
    logic           resp_ok;
    logic           timed_out;
    logic [1:0]     chg_code;
    logic [7:0]     chg_value;

    change_dispenser u_change_dispenser (
        .balance_i   (credit_q),
        .coin_code_o (chg_code),
        .coin_value_o(chg_value)
    );

    // A success only counts if it names our product alone and the credit covers it.
    always_comb begin
        coin_sum  = {1'b0, credit_q} + {1'b0, coin_value(coin_type)};
        coin_fits = (coin_sum <= 9'(MAX_CREDIT));
        dispense  = {date, carrot, banana, apple};
        any_resp  = (|dispense) | error;
        one_hot   = ((dispense & (dispense - 4'd1)) == 4'd0) && (dispense != 4'd0);
        price     = price_of(product_q);
        resp_ok   = !error && one_hot && dispense[product_q] && (credit_q >= price);
        timed_out = (timer_q == TW'(RESP_TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            credit_q       <= 8'd0;
            product_q      <= 2'b00;
            timer_q        <= '0;
            buy_q          <= 1'b0;
            coin_reject_q  <= 1'b0;
            vend_ok_q      <= 1'b0;
            vend_fail_q    <= 1'b0;
            change_valid_q <= 1'b0;
            change_coin_q  <= 2'b00;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            product_q      <= product_d;
            timer_q        <= timer_d;
            buy_q          <= buy_d;
            coin_reject_q  <= coin_reject_d;
            vend_ok_q      <= vend_ok_d;
            vend_fail_q    <= vend_fail_d;
            change_valid_q <= change_valid_d;
            change_coin_q  <= change_coin_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        product_d = product_q;
        timer_d   = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (cancel) begin
                    if (credit_q != 8'd0) state_d = ST_CHANGE;
                end else begin
                    if (coin_valid && coin_fits) credit_d = coin_sum[7:0];
                    if (select_valid) begin
                        product_d = select_product;
                        state_d   = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                timer_d = '0;
            end
            ST_WAIT: begin
                if (any_resp) begin
                    state_d = ST_IDLE;
                    if (resp_ok) begin
                        credit_d = credit_q - price;
                        if (credit_q != price) state_d = ST_CHANGE;
                    end
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_CHANGE: begin
                credit_d = credit_q - chg_value;
                if (credit_q == chg_value) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        buy_d          = (state_d == ST_REQ);
        coin_reject_d  = coin_valid && ((state_q != ST_IDLE) || cancel || !coin_fits);
        vend_ok_d      = (state_q == ST_WAIT) && any_resp && resp_ok;
        vend_fail_d    = (state_q == ST_WAIT) && (any_resp ? !resp_ok : timed_out);
        change_valid_d = (state_q == ST_CHANGE) && (chg_value != 8'd0);
        change_coin_d  = change_valid_d ? chg_code : 2'b00;
    end

    assign buy          = buy_q;
    assign product      = product_q;
    assign credit       = credit_q;
    assign coin_reject  = coin_reject_q;
    assign vend_ok      = vend_ok_q;
    assign vend_fail    = vend_fail_q;
    assign change_valid = change_valid_q;
    assign change_coin  = change_coin_q;
    assign busy         = (state_q != ST_IDLE);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_credit_manager.sv
// Directed bench for credit_manager: per-cycle vector table with expected outputs,
// plus a hand-written response-timeout sequence.
module tb_credit_manager;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       select_valid = 1'b0;
    logic [1:0] select_product = 2'b00;
    logic       cancel = 1'b0;
    logic       apple = 1'b0, banana = 1'b0, carrot = 1'b0, date = 1'b0, error = 1'b0;
    logic       buy, coin_reject, vend_ok, vend_fail, change_valid, busy;
    logic [1:0] product, change_coin;
    logic [7:0] credit;
    state_e     state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    credit_manager #(.MAX_CREDIT(250), .RESP_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .select_valid(select_valid), .select_product(select_product),
        .cancel(cancel),
        .apple(apple), .banana(banana), .carrot(carrot), .date(date), .error(error),
        .buy(buy), .product(product), .credit(credit), .coin_reject(coin_reject),
        .vend_ok(vend_ok), .vend_fail(vend_fail),
        .change_valid(change_valid), .change_coin(change_coin),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // resp packs {apple, banana, carrot, date, error}
    typedef struct {
        logic       rst_n;
        logic       cv;
        logic [1:0] ct;
        logic       sv;
        logic [1:0] sp;
        logic       cn;
        logic [4:0] resp;
        logic [7:0] e_credit;
        logic       e_buy;
        logic       e_rej;
        logic       e_ok;
        logic       e_fail;
        logic       e_chv;
        logic [1:0] e_chc;
        logic       e_busy;
        logic       chk_prod;
        logic [1:0] e_prod;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst_n, input logic cv, input logic [1:0] ct,
        input logic sv, input logic [1:0] sp, input logic cn, input logic [4:0] resp,
        input logic [7:0] e_credit, input logic e_buy, input logic e_rej,
        input logic e_ok, input logic e_fail, input logic e_chv, input logic [1:0] e_chc,
        input logic e_busy, input logic chk_prod, input logic [1:0] e_prod);
        vec_t r;
        r.rst_n = rst_n; r.cv = cv; r.ct = ct; r.sv = sv; r.sp = sp; r.cn = cn;
        r.resp = resp; r.e_credit = e_credit; r.e_buy = e_buy; r.e_rej = e_rej;
        r.e_ok = e_ok; r.e_fail = e_fail; r.e_chv = e_chv; r.e_chc = e_chc;
        r.e_busy = e_busy; r.chk_prod = chk_prod; r.e_prod = e_prod;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; select_valid = 1'b0;
        select_product = 2'b00; cancel = 1'b0;
        {apple, banana, carrot, date, error} = 5'b00000;
    endtask

    task automatic apply_row(input vec_t r, input int idx);
        reset = r.rst_n; coin_valid = r.cv; coin_type = r.ct;
        select_valid = r.sv; select_product = r.sp; cancel = r.cn;
        {apple, banana, carrot, date, error} = r.resp;
        @(posedge clk);
        #1;
        check($sformatf("row%0d credit", idx), credit, r.e_credit);
        check($sformatf("row%0d buy", idx), {7'd0, buy}, {7'd0, r.e_buy});
        check($sformatf("row%0d coin_reject", idx), {7'd0, coin_reject}, {7'd0, r.e_rej});
        check($sformatf("row%0d vend_ok", idx), {7'd0, vend_ok}, {7'd0, r.e_ok});
        check($sformatf("row%0d vend_fail", idx), {7'd0, vend_fail}, {7'd0, r.e_fail});
        check($sformatf("row%0d change_valid", idx), {7'd0, change_valid}, {7'd0, r.e_chv});
        check($sformatf("row%0d change_coin", idx), {6'd0, change_coin}, {6'd0, r.e_chc});
        check($sformatf("row%0d busy", idx), {7'd0, busy}, {7'd0, r.e_busy});
        if (r.chk_prod) check($sformatf("row%0d product", idx), {6'd0, product}, {6'd0, r.e_prod});
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply_row(tbl[i], i);
        tbl.delete();
    endtask

    initial begin
        int cycles;
        bit seen_fail;

        // reset, then cancel with zero credit stays idle
        tbl.push_back(mk(0,0,0,0,0,0,5'b00000,   0,0,0,0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,1,5'b00000,   0,0,0,0,0,0,0,0,0,0));
        // 100 + 25, apple bought, change 25 + 25
        tbl.push_back(mk(1,1,3,0,0,0,5'b00000, 100,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,2,0,0,0,5'b00000, 125,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,0,5'b00000, 125,1,0,0,0,0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000, 125,0,0,0,0,0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b10000,  50,0,0,1,0,0,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000,  25,0,0,0,0,1,2,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000,   0,0,0,0,0,1,2,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000,   0,0,0,0,0,0,0,0,0,0));
        // 10, then 10 with select date in the same cycle; error response
        tbl.push_back(mk(1,1,1,0,0,0,5'b00000,  10,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,1,3,0,5'b00000,  20,1,0,0,0,0,0,1,1,3));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000,  20,0,0,0,0,0,0,1,1,3));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00001,  20,0,0,0,1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000,  20,0,0,0,0,0,0,0,0,0));
        // cancel 20 -> 10, 10
        tbl.push_back(mk(1,0,0,0,0,1,5'b00000,  20,0,0,0,0,0,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000,  10,0,0,0,0,1,1,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000,   0,0,0,0,0,1,1,0,0,0));
        // fill to 250, overflow coin rejected, cancel beats select and rejects coin
        tbl.push_back(mk(1,1,3,0,0,0,5'b00000, 100,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,3,0,0,0,5'b00000, 200,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,2,0,0,0,5'b00000, 225,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,2,0,0,0,5'b00000, 250,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,5'b00000, 250,0,1,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,2,1,5'b00000, 250,0,1,0,0,0,0,1,0,0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1,0,0,0,0,0,5'b00000, 8'(225 - 25 * i),0,0,0,0,1,2,
                             (i < 9),0,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000,   0,0,0,0,0,0,0,0,0,0));
        // 25 + 5, select banana and let it time out
        tbl.push_back(mk(1,1,2,0,0,0,5'b00000,  25,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,5'b00000,  30,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1,0,5'b00000,  30,1,0,0,0,0,0,1,1,1));
        run_table();

        idle_inputs();
        cycles = 0;
        seen_fail = 0;
        while (cycles < 40 && !seen_fail) begin
            @(posedge clk);
            #1;
            cycles++;
            if (vend_fail === 1'b1) seen_fail = 1;
            else if (cycles > 1 && busy !== 1'b1) cycles = 40;
        end
        check("timeout vend_fail seen", {7'd0, seen_fail}, 8'd1);
        n_checks++;
        if (cycles < 15 || cycles > 17) begin
            n_fail++;
            $display("FAIL timeout latency: got %0d cycles expected 15..17", cycles);
        end
        check("timeout credit", credit, 8'd30);
        check("timeout busy", {7'd0, busy}, 8'd0);
        check("timeout vend_ok", {7'd0, vend_ok}, 8'd0);

        // carrot request answered with carrot: credit exactly consumed, no change
        tbl.push_back(mk(1,0,0,1,2,0,5'b00000,  30,1,0,0,0,0,0,1,1,2));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000,  30,0,0,0,0,0,0,1,1,2));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00100,   0,0,0,1,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000,   0,0,0,0,0,0,0,0,0,0));
        // coin during WAIT, wrong product, multiple bits
        tbl.push_back(mk(1,1,3,0,0,0,5'b00000, 100,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,0,5'b00000, 100,1,0,0,0,0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000, 100,0,0,0,0,0,0,1,1,0));
        tbl.push_back(mk(1,1,2,0,0,0,5'b00000, 100,0,1,0,0,0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b01000, 100,0,0,0,1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,0,5'b00000, 100,1,0,0,0,0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000, 100,0,0,0,0,0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b11000, 100,0,0,0,1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1,5'b00000, 100,0,0,0,0,0,0,1,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,0,0,0,0,0,5'b00000, 8'(75 - 25 * i),0,0,0,0,1,2,
                             (i < 3),0,0));
        // apple success with only 20 credit must fail without underflow
        tbl.push_back(mk(1,1,1,0,0,0,5'b00000,  10,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,5'b00000,  20,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,0,5'b00000,  20,1,0,0,0,0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000,  20,0,0,0,0,0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b10000,  20,0,0,0,1,0,0,0,0,0));
        // build 35, cancel, reset while in CHANGE forfeits the credit
        tbl.push_back(mk(1,1,1,0,0,0,5'b00000,  30,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,5'b00000,  35,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1,5'b00000,  35,0,0,0,0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,5'b00000,   0,0,0,0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,5'b00000,   0,0,0,0,0,0,0,0,0,0));
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
